dbus_sram_responder: RTL and testbench
======================================

// Module: dbus_sram_responder
// PURPOSE
//   Responder end of the core data-memory port: accepts load/store requests issued by
//   the mem stage and services them from a local word-organised SRAM array.
//   Adds configurable wait states, byte-lane writes and bus-error reporting.
//   Sits between mem and the data-side address map in place of the fixed-latency dpram.
// PARAMETERS
//   ADDR_WIDTH   32        request address width (byte address)
//   DATA_WIDTH   32        data width; fixed 4 byte lanes
//   MEM_WORDS    1024      array depth in words; power of two, >= 2
//   BASE_ADDR    32'h0     byte address of word 0; aligned to 4*MEM_WORDS
//   WAIT_STATES  1         extra cycles between accept and response, 0..15
// PORTS
//   clk_i        in   1    clock; all state updates on the rising edge
//   rst_i        in   1    reset, asynchronous, active-low
//   req_ce_i     in   1    request valid
//   req_we_i     in   1    1 = store, 0 = load
//   req_addr_i   in   32   byte address
//   req_be_i     in   4    byte enables; lane n = data[8n+7:8n]
//   req_data_i   in   32   store data, already lane-aligned
//   req_ready_o  out  1    responder can accept a request this cycle
//   rsp_valid_o  out  1    one-cycle pulse: response present
//   rsp_data_o   out  32   load data (full word); 0 for stores and errors
//   rsp_err_o    out  1    qualifies rsp_valid_o: access rejected
// BEHAVIOUR
//   Reset (rst_i=0): state IDLE, wait counter 0, req_ready_o=1, rsp_valid_o=0,
//     rsp_data_o=0, rsp_err_o=0. Array contents are not reset.
//   Handshake: request accepted on an edge where req_ce_i && req_ready_o. Accept
//     latches we, addr, be and data; later changes on req_* are ignored until IDLE.
//   FSM:
//   - IDLE -> WAIT on accept if WAIT_STATES>0, load counter = WAIT_STATES-1.
//   - IDLE -> RESP on accept if WAIT_STATES==0.
//   - WAIT: counter decrements each cycle; -> RESP when counter==0.
//   - RESP -> IDLE unconditionally after one cycle.
//   Ready: req_ready_o=1 only in IDLE. One outstanding request, no pipelining.
//   Latency: accept at edge N -> rsp_valid_o high for exactly the cycle after edge
//     N+1+WAIT_STATES. Next accept no earlier than edge N+2+WAIT_STATES.
//   Access: performed on the edge entering RESP; word index = (addr-BASE_ADDR)>>2.
//   - Store: write only lanes with be=1; rsp_data_o=0.
//   - Load: rsp_data_o = full stored word, unshifted; be not used for masking.
//   Errors: rsp_err_o=1, no array write, rsp_data_o=0, if any of:
//   - addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS);
//   - be not one of 0001/0010/0100/1000/0011/1100/1111;
//   - be lanes not matching addr[1:0]: byte needs lane==addr[1:0], half needs addr[0]=0
//     with 0011@00 / 1100@10, word needs addr[1:0]=00.
//   Outputs: rsp_data_o/rsp_err_o registered, hold value until the next response.
//     rsp_valid_o deasserts in the cycle after RESP.
//   Reset mid-operation: pending request dropped, no write, no response, back to IDLE.
//   Width rules: address compare in ADDR_WIDTH bits, no wrap at top of the address space.
// TESTING
//   1 Store 32'hDEADBEEF be=1111 @BASE+8, then load @BASE+8 (WAIT_STATES=1) -> each
//     rsp_valid_o exactly 2 cycles after accept edge; load data=DEADBEEF, err=0.
//   2 Store 32'h0000AA00 be=0010 @BASE+9 over word 11223344 -> load returns 1122AA44.
//   3 Store be=1100 @BASE+0 -> rsp_err_o=1, word unchanged. Load @BASE+4*MEM_WORDS
//     -> rsp_err_o=1, data=0.
//   4 Hold req_ce_i=1 continuously with changing addresses -> req_ready_o low in
//     WAIT/RESP; accepts exactly WAIT_STATES+2 cycles apart; stale req_* ignored.
//   5 Assert rst_i=0 during WAIT of a store -> no rsp_valid_o, target word unchanged,
//     req_ready_o=1 immediately.
//   6 Rerun 1 with WAIT_STATES=0 and 15 -> latency 1 and 16 cycles, same data.

Source files
------------

// File: rtl/dbus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_sram_responder
// Brief    : Data-port responder serving loads/stores from a local word SRAM,
//            with programmable wait states, byte-lane writes and bus errors.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_sram_responder #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_ce_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [3:0]            req_be_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  req_ready_o,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o
);

  localparam int unsigned         c_idx_w     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] c_span      = (ADDR_WIDTH+1)'(4 * MEM_WORDS);
  localparam logic [3:0]          c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_cur_we;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic [3:0]            w_cur_be;
  logic [DATA_WIDTH-1:0] w_cur_data;
  logic                  w_wr_en;
  logic                  w_rsp_err;

  // Range check is done on the unwrapped difference so addresses below the
  // base or past the top of the array never alias back into it.
  function automatic logic access_err(input logic [ADDR_WIDTH-1:0] a, input logic [3:0] b);
    logic [ADDR_WIDTH-1:0] off;
    logic                  in_range;
    logic                  lane_ok;
    off      = a - BASE_ADDR;
    in_range = (a >= BASE_ADDR) && ({1'b0, off} < c_span);
    case ({b, a[1:0]})
      6'b0001_00, 6'b0010_01, 6'b0100_10, 6'b1000_11,
      6'b0011_00, 6'b1100_10, 6'b1111_00: lane_ok = 1'b1;
      default:                            lane_ok = 1'b0;
    endcase
    return !(in_range && lane_ok);
  endfunction

  function automatic logic [c_idx_w-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return c_idx_w'((a - BASE_ADDR) >> 2);
  endfunction

  assign req_ready_o = (r_state == ST_IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_data_o  = r_rsp_data;

  assign w_accept     = req_ce_i && req_ready_o;
  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

  // With zero wait states the array is written on the accept edge itself,
  // before the request registers hold the new request.
  assign w_cur_we   = (r_state == ST_IDLE) ? req_we_i   : r_we;
  assign w_cur_addr = (r_state == ST_IDLE) ? req_addr_i : r_addr;
  assign w_cur_be   = (r_state == ST_IDLE) ? req_be_i   : r_be;
  assign w_cur_data = (r_state == ST_IDLE) ? req_data_i : r_data;
  assign w_wr_en    = w_enter_resp && w_cur_we && !access_err(w_cur_addr, w_cur_be);
  assign w_rsp_err  = access_err(r_addr, r_be);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= c_wait_load;
        r_we   <= req_we_i;
        r_addr <= req_addr_i;
        r_be   <= req_be_i;
        r_data <= req_data_i;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Response is presented on the edge leaving RESP; nothing can write the
  // array between the access edge and here, so reading now is equivalent.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else if (r_state == ST_RESP) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_rsp_err;
      r_rsp_data  <= (r_we || w_rsp_err) ? '0 : r_mem[word_idx(r_addr)];
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_cur_be[i]) r_mem[word_idx(w_cur_addr)][8*i +: 8] <= w_cur_data[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_sram_responder.sv
`default_nettype none
// Directed bench for dbus_sram_responder: three instances (1, 0 and 15 wait
// states) share one request bus; 'sel' picks which one sees req_ce_i.
module tb_dbus_sram_responder;

  localparam logic [31:0] c_base = 32'h1000_0000;
  localparam int          c_mw   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  int          sel;
  logic        ce_g [3];
  logic        rdy  [3];
  logic        vld  [3];
  logic [31:0] rdat [3];
  logic        rerr [3];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign ce_g[0] = ce && (sel == 0);
  assign ce_g[1] = ce && (sel == 1);
  assign ce_g[2] = ce && (sel == 2);

  dbus_sram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(c_mw),
                        .BASE_ADDR(c_base), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst_n), .req_ce_i(ce_g[0]), .req_we_i(we),
    .req_addr_i(addr), .req_be_i(be), .req_data_i(wdata),
    .req_ready_o(rdy[0]), .rsp_valid_o(vld[0]), .rsp_data_o(rdat[0]), .rsp_err_o(rerr[0]));

  dbus_sram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(c_mw),
                        .BASE_ADDR(c_base), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst_n), .req_ce_i(ce_g[1]), .req_we_i(we),
    .req_addr_i(addr), .req_be_i(be), .req_data_i(wdata),
    .req_ready_o(rdy[1]), .rsp_valid_o(vld[1]), .rsp_data_o(rdat[1]), .rsp_err_o(rerr[1]));

  dbus_sram_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(c_mw),
                        .BASE_ADDR(c_base), .WAIT_STATES(15)) u_ws15 (
    .clk_i(clk), .rst_i(rst_n), .req_ce_i(ce_g[2]), .req_we_i(we),
    .req_addr_i(addr), .req_be_i(be), .req_data_i(wdata),
    .req_ready_o(rdy[2]), .rsp_valid_o(vld[2]), .rsp_data_o(rdat[2]), .rsp_err_o(rerr[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance 'sel': checks accept, latency, data, error and
  // that the valid pulse lasts a single cycle.
  task automatic do_req(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input int exp_lat,
                        input logic [31:0] exp_d, input logic exp_e);
    int k;
    int lat;
    k = 0;
    @(negedge clk);
    while (!rdy[sel] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_ready"}, 32'(rdy[sel]), 32'd1);
    we = w; addr = a; be = b; wdata = d; ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; addr = 32'hFFFF_FFF0; be = 4'h0; wdata = 32'h0BAD_0BAD;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (vld[sel]) begin
        lat = i - 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat < 0 && vld[sel]) lat = 40;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rdat[sel], exp_d);
    chk({tag, "_err"}, 32'(rerr[sel]), 32'(exp_e));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(vld[sel]), 32'd0);
  endtask

  initial begin
    int          acc_cyc [$];
    logic [31:0] got_q   [$];
    logic [31:0] stream_exp [4];
    int          seen;

    rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", 32'(rdy[0]), 32'd1);
    chk("reset_valid", 32'(vld[0]), 32'd0);
    chk("reset_data",  rdat[0], 32'd0);
    chk("reset_err",   32'(rerr[0]), 32'd0);
    chk("reset_ready_ws15", 32'(rdy[2]), 32'd1);

    // Basic store/load, one wait state
    sel = 0;
    do_req("t1_st", 1'b1, c_base + 32'd8, 4'hF, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
    do_req("t1_ld", 1'b0, c_base + 32'd8, 4'hF, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);

    // Single byte lane merge
    do_req("t2_init", 1'b1, c_base + 32'd8, 4'hF, 32'h1122_3344, 2, 32'h0, 1'b0);
    do_req("t2_byte", 1'b1, c_base + 32'd9, 4'h2, 32'h0000_AA00, 2, 32'h0, 1'b0);
    do_req("t2_ld",   1'b0, c_base + 32'd8, 4'hF, 32'h0, 2, 32'h1122_AA44, 1'b0);

    // Error cases
    do_req("t3_init",  1'b1, c_base, 4'hF, 32'h5566_7788, 2, 32'h0, 1'b0);
    do_req("t3_badbe", 1'b1, c_base, 4'hC, 32'hFFFF_0000, 2, 32'h0, 1'b1);
    do_req("t3_ld0",   1'b0, c_base, 4'hF, 32'h0, 2, 32'h5566_7788, 1'b0);
    do_req("t3_top",   1'b0, c_base + 32'(4 * c_mw), 4'hF, 32'h0, 2, 32'h0, 1'b1);
    do_req("t3_below", 1'b0, c_base - 32'd4, 4'hF, 32'h0, 2, 32'h0, 1'b1);
    do_req("t3_be0101", 1'b0, c_base, 4'h5, 32'h0, 2, 32'h0, 1'b1);
    do_req("t3_misw",  1'b0, c_base + 32'd2, 4'hF, 32'h0, 2, 32'h0, 1'b1);
    do_req("t3_half2", 1'b0, c_base + 32'd2, 4'hC, 32'h0, 2, 32'h5566_7788, 1'b0);
    do_req("t3_last",  1'b0, c_base + 32'(4 * c_mw - 1), 4'h8, 32'h0, 2, 32'hxxxx_xxxx, 1'b0);

    // Back-to-back with ce held high and the address changing every cycle
    for (int i = 0; i < 4; i++)
      do_req("t4_pre", 1'b1, c_base + 32'(16 + 4 * i), 4'hF, 32'hA0A0_0000 + 32'(i), 2, 32'h0, 1'b0);
    stream_exp[0] = 32'hA0A0_0000;
    stream_exp[1] = 32'hA0A0_0003;
    stream_exp[2] = 32'hA0A0_0002;
    stream_exp[3] = 32'hA0A0_0001;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      addr = c_base + 32'(16 + 4 * (c % 4)); ce = 1'b1; we = 1'b0; be = 4'hF;
      if (rdy[0]) acc_cyc.push_back(c);
      @(posedge clk);
      #1;
      if (vld[0]) got_q.push_back(rdat[0]);
    end
    @(negedge clk);
    ce = 1'b0;
    chk("t4_n_accepts", 32'(acc_cyc.size()), 32'd4);
    chk("t4_n_rsp", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_cyc.size()) chk("t4_accept_cycle", 32'(acc_cyc[i]), 32'(3 * i));
      if (i < got_q.size())   chk("t4_rsp_data", got_q[i], stream_exp[i]);
    end

    // Reset while a store is waiting
    @(negedge clk);
    we = 1'b1; addr = c_base + 32'd8; be = 4'hF; wdata = 32'hCAFE_F00D; ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0;
    chk("t5_busy", 32'(rdy[0]), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_ready_now", 32'(rdy[0]), 32'd1);
    chk("t5_no_valid", 32'(vld[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (vld[0]) seen++;
    end
    chk("t5_no_rsp", 32'(seen), 32'd0);
    do_req("t5_ld", 1'b0, c_base + 32'd8, 4'hF, 32'h0, 2, 32'h1122_AA44, 1'b0);

    // Zero and maximum wait states
    sel = 1;
    do_req("t6_ws0_st", 1'b1, c_base + 32'd8, 4'hF, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
    do_req("t6_ws0_ld", 1'b0, c_base + 32'd8, 4'hF, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    do_req("t6_ws0_err", 1'b0, c_base + 32'd1, 4'hF, 32'h0, 1, 32'h0, 1'b1);
    sel = 2;
    do_req("t6_ws15_st", 1'b1, c_base + 32'd8, 4'hF, 32'hDEAD_BEEF, 16, 32'h0, 1'b0);
    do_req("t6_ws15_ld", 1'b0, c_base + 32'd8, 4'hF, 32'h0, 16, 32'hDEAD_BEEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
